cache_mem_responder: RTL and testbench
======================================

Name: cache_mem_responder

Overview:
- Backing-memory responder for the direct-mapped cache's memory interface. It accepts line-granular read and write requests on the mem_req fields and returns a single-cycle mem_data response after a fixed, parameterised latency.
- It holds the line storage itself, so it serves as the main-memory model and as the synthesizable memory-controller stub behind the cache FSM.
- It also keeps read and write request counters for bandwidth checks.

Parameters:
- ADDR_W, 32, request address width in bits (matches mem_req_type.addr).
- LINE_W, 128, line width in bits (matches mem_data_type.data); 16 bytes per line.
- IDX_W, 10, line-index bits; storage depth is 2**IDX_W lines.
- LATENCY, 4, cycles from request sample to response; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_req_valid  in  1  request strobe.
- mem_req_rw  in  1  1 = write line, 0 = read line.
- mem_req_addr  in  ADDR_W  byte address; bits [3:0] are ignored.
- mem_req_data  in  LINE_W  write line data.
- mem_data_valid  out  1  response strobe, one cycle per accepted request.
- mem_data_data  out  LINE_W  response line.
- busy  out  1  high while a request is outstanding; not high in the response cycle.
- rd_count  out  16  accepted reads, wraps modulo 2**16.
- wr_count  out  16  accepted writes, wraps modulo 2**16.

Behaviour:
- Reset values:
  - mem_data_valid=0, mem_data_data=0, busy=0, rd_count=0, wr_count=0, state=IDLE.
  - Storage is not cleared; unwritten lines read as X in simulation.
- Line index: idx = mem_req_addr[4+IDX_W-1:4]. Address bits above the index are ignored, so addresses alias modulo 2**IDX_W lines.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting down latency; count register is 8 bits.
  - RESP: single response cycle.
- Accept window: mem_req_valid is sampled only in IDLE or RESP. It is ignored in WAIT and never queued.
- A requester holding valid high through RESP issues a second request. The requester must deassert valid in the response cycle unless it intends a new request, as the cache does on write-back completion.
- Acceptance, at the edge ending sample cycle c:
  - Latch rw and idx.
  - Write: commit mem_req_data to storage at idx on this edge; response line = mem_req_data (echo).
  - Read: capture storage[idx] on this edge; response line = that value.
  - A read accepted in the response cycle of a write to the same idx returns the newly written data.
  - Increment rd_count or wr_count on this edge.
- Next state after acceptance:
  - LATENCY=1: go to RESP.
  - Otherwise: go to WAIT with count=LATENCY-2.
- WAIT: decrement count; move to RESP when count==0 is observed.
- RESP:
  - mem_data_valid=1 and mem_data_data=response line in cycle c+LATENCY only; busy=0.
  - If mem_req_valid=1 this cycle, accept a new request (rules above) and go to WAIT or RESP. Otherwise go to IDLE.
- Outside RESP, mem_data_valid=0 and mem_data_data=0.
- busy=1 in every cycle of WAIT, plus the RESP cycle of LATENCY=1 is excluded; busy is 0 in IDLE and RESP.
- Reset mid-operation: the pending request is dropped with no response. A write already committed stays in storage. Counters clear.
- Simultaneous rst and mem_req_valid: reset wins; nothing is accepted or written.
- Throughput: one request per LATENCY cycles when back-to-back.

Test Plan:
- LATENCY=4, write addr 0x0000_0120 data 0xA5A5...A5 in cycle 0 -> mem_data_valid=1 only in cycle 4 with echo data; wr_count=1; busy=1 in cycles 1-3.
- After the write, read addr 0x0000_0120 -> the response 4 cycles later carries 0xA5A5...A5; rd_count=1.
- Write-back then allocate: write 0x0000_0130 with data D1; in its response cycle present a read of 0x0000_0130 -> read accepted with no gap and returns D1 four cycles later; exactly two mem_data_valid pulses.
- Aliasing: write 0x0000_4010 with data D2, then read 0x0000_0010 (IDX_W=10) -> returns D2.
- Valid asserted in cycles 1-3 while in WAIT -> ignored; only one response; counters unchanged by the ignored pulses.
- rst asserted in cycle 2 of a pending read -> no response ever; rd_count=0. LATENCY=1 build -> response in the cycle after the sample, busy never 1.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Line-granular backing memory for the direct-mapped cache: fixed-latency
// single-cycle responses, in-block line storage, and read/write request counters.
//
// state | meaning
// IDLE  | waiting for a request
// WAIT  | counting down latency (count == 0 means RESP next)
// RESP  | single response cycle; a new request may be accepted here
module cache_mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int IDX_W   = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_data,
    output logic              mem_data_valid,
    output logic [LINE_W-1:0] mem_data_data,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    state_t            state;
    logic [7:0]        count;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] storage [2**IDX_W];

    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic [LINE_W-1:0] new_line;
    logic              unused_addr_bits;

    assign idx      = mem_req_addr[4+IDX_W-1:4];
    assign accept   = !rst && mem_req_valid && (state == IDLE || state == RESP);
    // The write commits on the accepting edge, so a write's echo and a later read agree.
    assign new_line = mem_req_rw ? mem_req_data : storage[idx];

    assign unused_addr_bits = ^{mem_req_addr[ADDR_W-1:4+IDX_W], mem_req_addr[3:0]};

    always_ff @(posedge clk) begin
        if (accept && mem_req_rw) begin
            storage[idx] <= mem_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= 8'd0;
            line_q         <= '0;
            mem_data_valid <= 1'b0;
            mem_data_data  <= '0;
            busy           <= 1'b0;
            rd_count       <= 16'd0;
            wr_count       <= 16'd0;
        end else begin
            mem_data_valid <= 1'b0;
            mem_data_data  <= '0;
            busy           <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (mem_req_valid) begin
                        line_q <= new_line;
                        if (mem_req_rw) begin
                            wr_count <= wr_count + 16'd1;
                        end else begin
                            rd_count <= rd_count + 16'd1;
                        end
                        if (LATENCY == 1) begin
                            state          <= RESP;
                            mem_data_valid <= 1'b1;
                            mem_data_data  <= new_line;
                        end else begin
                            state <= WAIT;
                            count <= CNT_LOAD;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (count == 8'd0) begin
                        state          <= RESP;
                        mem_data_valid <= 1'b1;
                        mem_data_data  <= line_q;
                    end else begin
                        count <= count - 8'd1;
                        busy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a per-cycle vector table on a LATENCY=4
// instance plus hand sequences for reset corners and a LATENCY=1 instance.
module tb_cache_mem_responder;

    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] X5 = {16{8'h5A}};
    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    localparam logic [127:0] D3 = 128'h1357_9BDF_2468_ACE0_0F0F_F0F0_AAAA_5555;
    localparam logic [127:0] JK = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         v, rw, v1, rw1;
    logic [31:0]  addr, addr1;
    logic [127:0] wdata, wdata1;
    logic         dv, busy, dv1, busy1;
    logic [127:0] ddata, ddata1;
    logic [15:0]  rdc, wrc, rdc1, wrc1;

    cache_mem_responder #(.LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .mem_req_valid(v), .mem_req_rw(rw),
        .mem_req_addr(addr), .mem_req_data(wdata), .mem_data_valid(dv),
        .mem_data_data(ddata), .busy(busy), .rd_count(rdc), .wr_count(wrc)
    );

    cache_mem_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_req_valid(v1), .mem_req_rw(rw1),
        .mem_req_addr(addr1), .mem_req_data(wdata1), .mem_data_valid(dv1),
        .mem_data_data(ddata1), .busy(busy1), .rd_count(rdc1), .wr_count(wrc1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic busy1_seen = 1'b0;

    always @(negedge clk) if (busy1 === 1'b1) busy1_seen = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         v;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
        logic         ev;
        logic [127:0] ed;
        logic         eb;
        logic [15:0]  erd;
        logic [15:0]  ewr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic iv, input logic irw, input logic [31:0] ia,
                                input logic [127:0] id, input logic ev, input logic [127:0] ed,
                                input logic eb, input logic [15:0] erd, input logic [15:0] ewr);
        vec_t t;
        t.v = iv; t.rw = irw; t.addr = ia; t.data = id;
        t.ev = ev; t.ed = ed; t.eb = eb; t.erd = erd; t.ewr = ewr;
        vecs.push_back(t);
    endfunction

    initial begin
        int lat;
        logic seen;

        // cycle-by-cycle: inputs presented this cycle, outputs expected this cycle
        add(1, 1, 32'h120,  A5, 0, 0,  0, 0, 0);   // 0: write 0x120
        add(0, 0, 32'h0,    0,  0, 0,  1, 0, 1);
        add(0, 0, 32'h0,    0,  0, 0,  1, 0, 1);
        add(0, 0, 32'h0,    0,  0, 0,  1, 0, 1);
        add(0, 0, 32'h0,    0,  1, A5, 0, 0, 1);   // 4: echo response
        add(1, 0, 32'h120,  0,  0, 0,  0, 0, 1);   // 5: read 0x120
        add(0, 0, 32'h0,    0,  0, 0,  1, 1, 1);
        add(0, 0, 32'h0,    0,  0, 0,  1, 1, 1);
        add(0, 0, 32'h0,    0,  0, 0,  1, 1, 1);
        add(0, 0, 32'h0,    0,  1, A5, 0, 1, 1);   // 9
        add(1, 1, 32'h130,  D1, 0, 0,  0, 1, 1);   // 10: write-back 0x130
        add(0, 0, 32'h0,    0,  0, 0,  1, 1, 2);
        add(0, 0, 32'h0,    0,  0, 0,  1, 1, 2);
        add(0, 0, 32'h0,    0,  0, 0,  1, 1, 2);
        add(1, 0, 32'h130,  0,  1, D1, 0, 1, 2);   // 14: read in response cycle
        add(0, 0, 32'h0,    0,  0, 0,  1, 2, 2);
        add(0, 0, 32'h0,    0,  0, 0,  1, 2, 2);
        add(0, 0, 32'h0,    0,  0, 0,  1, 2, 2);
        add(0, 0, 32'h0,    0,  1, D1, 0, 2, 2);   // 18
        add(1, 1, 32'h4010, D2, 0, 0,  0, 2, 2);   // 19: aliasing write
        add(0, 0, 32'h0,    0,  0, 0,  1, 2, 3);
        add(0, 0, 32'h0,    0,  0, 0,  1, 2, 3);
        add(0, 0, 32'h0,    0,  0, 0,  1, 2, 3);
        add(0, 0, 32'h0,    0,  1, D2, 0, 2, 3);   // 23
        add(1, 0, 32'h10,   0,  0, 0,  0, 2, 3);   // 24: read alias
        add(0, 0, 32'h0,    0,  0, 0,  1, 3, 3);
        add(0, 0, 32'h0,    0,  0, 0,  1, 3, 3);
        add(0, 0, 32'h0,    0,  0, 0,  1, 3, 3);
        add(0, 0, 32'h0,    0,  1, D2, 0, 3, 3);   // 28
        add(1, 0, 32'h120,  0,  0, 0,  0, 3, 3);   // 29: read, then pulses in WAIT
        add(1, 1, 32'h10,   JK, 0, 0,  1, 4, 3);
        add(1, 0, 32'h130,  0,  0, 0,  1, 4, 3);
        add(1, 1, 32'h120,  JK, 0, 0,  1, 4, 3);
        add(0, 0, 32'h0,    0,  1, A5, 0, 4, 3);   // 33
        add(0, 0, 32'h0,    0,  0, 0,  0, 4, 3);
        add(1, 0, 32'h10,   0,  0, 0,  0, 4, 3);   // 35: ignored write not committed
        add(0, 0, 32'h0,    0,  0, 0,  1, 5, 3);
        add(0, 0, 32'h0,    0,  0, 0,  1, 5, 3);
        add(0, 0, 32'h0,    0,  0, 0,  1, 5, 3);
        add(0, 0, 32'h0,    0,  1, D2, 0, 5, 3);   // 39
        add(0, 0, 32'h0,    0,  0, 0,  0, 5, 3);

        rst = 1'b1;
        v = 0; rw = 0; addr = 0; wdata = 0;
        v1 = 0; rw1 = 0; addr1 = 0; wdata1 = 0;
        step();
        step();
        chk("reset.valid", dv, 0);
        chk("reset.data", ddata, 0);
        chk("reset.busy", busy, 0);
        chk("reset.rd", rdc, 0);
        chk("reset.wr", wrc, 0);
        chk("reset1.valid", dv1, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i].v; rw = vecs[i].rw; addr = vecs[i].addr; wdata = vecs[i].data;
            chk($sformatf("vec%0d.valid", i), dv, vecs[i].ev);
            chk($sformatf("vec%0d.data", i), ddata, vecs[i].ed);
            chk($sformatf("vec%0d.busy", i), busy, vecs[i].eb);
            chk($sformatf("vec%0d.rd_count", i), rdc, vecs[i].erd);
            chk($sformatf("vec%0d.wr_count", i), wrc, vecs[i].ewr);
            step();
        end
        v = 0;

        // reset in cycle 2 of a pending read: no response, counters cleared
        v = 1; rw = 0; addr = 32'h120;
        step();
        v = 0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            if (dv !== 1'b0) seen = 1'b1;
            step();
        end
        chk("rst_mid.no_resp", seen, 0);
        chk("rst_mid.rd", rdc, 0);
        chk("rst_mid.wr", wrc, 0);

        // reset together with a write: nothing accepted, storage unchanged
        rst = 1'b1; v = 1; rw = 1; addr = 32'h120; wdata = X5;
        step();
        rst = 1'b0; v = 0;
        step();
        chk("rst_wr.wr", wrc, 0);
        v = 1; rw = 0; addr = 32'h120;
        step();
        v = 0;
        lat = 1;
        while (dv !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        chk("rst_wr.latency", lat, 4);
        chk("rst_wr.data", ddata, A5);
        chk("rst_wr.rd", rdc, 1);
        chk("rst_wr.wr_after", wrc, 0);

        // LATENCY=1 instance: response the cycle after the sample, back-to-back
        v1 = 1; rw1 = 1; addr1 = 32'h50; wdata1 = D3;
        chk("l1.idle_valid", dv1, 0);
        step();
        chk("l1.wr_valid", dv1, 1);
        chk("l1.wr_data", ddata1, D3);
        chk("l1.wr_busy", busy1, 0);
        chk("l1.wr_count", wrc1, 1);
        rw1 = 0; wdata1 = 0;
        step();
        chk("l1.rd_valid", dv1, 1);
        chk("l1.rd_data", ddata1, D3);
        chk("l1.rd_count", rdc1, 1);
        v1 = 0;
        step();
        chk("l1.after_valid", dv1, 0);
        chk("l1.after_data", ddata1, 0);
        step();
        chk("l1.busy_never", busy1_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
